cpu_pipeline_ctrl: RTL

- Consumer end of the pipeline stall vector.
- Turns the 5-bit per-stage stall request into per-stage register enables and bubble insertion.
- Tracks the valid bit and destination register number of each instruction in the EX, MEM and WB slots.
- Produces the realtime EX/MEM write-register numbers that feed hazard detection, which closes the stall loop.
- Sits between the hazard unit and the IF/ID/EX/MEM/WB pipeline registers.

---
 rtl/cpu_pipeline_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline stall consumer: per-stage enables/bubbles plus EX/MEM/WB valid and write-register tracking.
// Optional statistics counters are built when CPU_PIPELINE_STATS_EN is defined.
`ifndef HAZARD_STALL_IF
  `define HAZARD_STALL_IF  0
`endif
`ifndef HAZARD_STALL_ID
  `define HAZARD_STALL_ID  1
`endif
`ifndef HAZARD_STALL_EX
  `define HAZARD_STALL_EX  2
`endif
`ifndef HAZARD_STALL_MEM
  `define HAZARD_STALL_MEM 3
`endif
`ifndef HAZARD_STALL_WB
  `define HAZARD_STALL_WB  4
`endif

module cpu_pipeline_ctrl #(
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [4:0]               stalls,
  input  logic                     id_valid,
  input  logic [4:0]               reg_write_num_id,
  output logic [4:0]               stage_en,
  output logic [4:0]               bubble,
  output logic                     valid_ex,
  output logic                     valid_mem,
  output logic                     valid_wb,
  output logic [4:0]               reg_write_num_realtime_ex,
  output logic [4:0]               reg_write_num_realtime_mem,
  output logic [4:0]               reg_write_num_wb,
  output logic [COUNTER_WIDTH-1:0] stall_cycles,
  output logic [COUNTER_WIDTH-1:0] bubble_count,
  output logic [COUNTER_WIDTH-1:0] retired_count
);

  localparam int S_IF  = `HAZARD_STALL_IF;
  localparam int S_ID  = `HAZARD_STALL_ID;
  localparam int S_EX  = `HAZARD_STALL_EX;
  localparam int S_MEM = `HAZARD_STALL_MEM;
  localparam int S_WB  = `HAZARD_STALL_WB;

  logic hold_if, hold_id, hold_ex, hold_mem, hold_wb;

  // Slot state: p0 = EX, p1 = MEM, p2 = WB
  logic       vld_p0, vld_p1, vld_p2;
  logic [4:0] wnum_p0, wnum_p1, wnum_p2;

  // Hold propagates upstream so the most downstream stalled stage dominates
  always_comb begin
    hold_wb  = stalls[S_WB];
    hold_mem = stalls[S_MEM] | hold_wb;
    hold_ex  = stalls[S_EX]  | hold_mem;
    hold_id  = stalls[S_ID]  | hold_ex;
    hold_if  = stalls[S_IF]  | hold_id;

    stage_en        = '1;
    stage_en[S_IF]  = ~hold_if;
    stage_en[S_ID]  = ~hold_id;
    stage_en[S_EX]  = ~hold_ex;
    stage_en[S_MEM] = ~hold_mem;
    stage_en[S_WB]  = ~hold_wb;

    bubble          = '0;
    bubble[S_EX]    = hold_id  & ~hold_ex;
    bubble[S_MEM]   = hold_ex  & ~hold_mem;
    bubble[S_WB]    = hold_mem & ~hold_wb;
  end

  // Stage boundary ID -> EX -> MEM -> WB; invalid slots always carry wnum 0
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      wnum_p0 <= '0;
      wnum_p1 <= '0;
      wnum_p2 <= '0;
    end else begin
      if (!hold_ex) begin
        if (hold_id) begin
          vld_p0  <= 1'b0;
          wnum_p0 <= '0;
        end else begin
          vld_p0  <= id_valid;
          wnum_p0 <= id_valid ? reg_write_num_id : 5'd0;
        end
      end
      if (!hold_mem) begin
        if (hold_ex) begin
          vld_p1  <= 1'b0;
          wnum_p1 <= '0;
        end else begin
          vld_p1  <= vld_p0;
          wnum_p1 <= wnum_p0;
        end
      end
      if (!hold_wb) begin
        if (hold_mem) begin
          vld_p2  <= 1'b0;
          wnum_p2 <= '0;
        end else begin
          vld_p2  <= vld_p1;
          wnum_p2 <= wnum_p1;
        end
      end
    end
  end

  assign valid_ex                   = vld_p0;
  assign valid_mem                  = vld_p1;
  assign valid_wb                   = vld_p2;
  assign reg_write_num_realtime_ex  = wnum_p0;
  assign reg_write_num_realtime_mem = wnum_p1;
  assign reg_write_num_wb           = wnum_p2;

`ifdef CPU_PIPELINE_STATS_EN
  logic [COUNTER_WIDTH-1:0] stall_cnt, bubble_cnt, retire_cnt;

  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
    return (&v) ? v : v + COUNTER_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      if (hold_id)             stall_cnt  <= sat_inc(stall_cnt);
      if (bubble[S_EX])        bubble_cnt <= sat_inc(bubble_cnt);
      if (vld_p2 && !hold_wb)  retire_cnt <= sat_inc(retire_cnt);
    end
  end

  assign stall_cycles  = stall_cnt;
  assign bubble_count  = bubble_cnt;
  assign retired_count = retire_cnt;
`else
  assign stall_cycles  = '0;
  assign bubble_count  = '0;
  assign retired_count = '0;
`endif

endmodule
